// File: rtl/param_fifo_pkg.sv
// Shared defaults and types for param_fifo. Queue owners (ROB, LSB) override
// the defaults at instantiation.
package param_fifo_pkg;

  localparam int FIFO_DAT_W    = 32;
  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_ADDR_W   = 4;
  localparam int FIFO_AFULL_TH = 14;

  // Status flags, registered together from the next-state occupancy
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0};

endpackage

// File: rtl/param_fifo_ctrl.sv
// Pointer, occupancy and flag control for param_fifo. Storage lives in the
// top; this block decides which requests are accepted and where they land.
module param_fifo_ctrl
  import param_fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AFULL_TH = FIFO_AFULL_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  output logic              push_ok,
  output logic              pop_ok,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] tail,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              afull
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C = AFULL_TH[ADDR_W:0];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_flags_t       flags_q, flags_d;

  // A pop frees a slot in the same cycle, so a full queue can still take a push
  assign pop_ok  = en & ~flush & pop & ~flags_q.empty;
  assign push_ok = en & ~flush & push & (~flags_q.full | pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + ADDR_W'(pop_ok);
      tail_d  = tail_q + ADDR_W'(push_ok);
      count_d = count_q + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
    end
    flags_d.full  = (count_d == DEPTH_C);
    flags_d.empty = (count_d == '0);
    flags_d.afull = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flags_q <= FIFO_FLAGS_RST;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = flags_q.full;
  assign empty = flags_q.empty;
  assign afull = flags_q.afull;

endmodule

// File: rtl/param_fifo.sv
// First-word-fall-through synchronous FIFO with flush, occupancy and slot
// indices. Head data is read straight from the register array.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DAT_W    = FIFO_DAT_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AFULL_TH = FIFO_AFULL_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DAT_W-1:0]  i_WrDat,
  input  logic              i_pop,
  output logic [DAT_W-1:0]  o_RdDat,
  output logic              o_RdVld,
  output logic              o_push_ok,
  output logic              o_pop_ok,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic [ADDR_W:0]   o_count,
  output logic [ADDR_W-1:0] o_head_idx,
  output logic [ADDR_W-1:0] o_tail_idx
);

  logic              push_ok;
  logic              pop_ok;
  logic              empty;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [DAT_W-1:0]  dat_q [DEPTH];

  param_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .AFULL_TH (AFULL_TH)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .flush   (i_flush),
    .push    (i_push),
    .pop     (i_pop),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .head    (head),
    .tail    (tail),
    .count   (o_count),
    .full    (o_full),
    .empty   (empty),
    .afull   (o_afull)
  );

  // Reset clears the array so o_RdDat reads 0 out of reset; flush leaves it stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (push_ok) begin
      dat_q[tail] <= i_WrDat;
    end
  end

  assign o_RdDat    = dat_q[head];
  assign o_RdVld    = ~empty;
  assign o_empty    = empty;
  assign o_push_ok  = push_ok;
  assign o_pop_ok   = pop_ok;
  assign o_head_idx = head;
  assign o_tail_idx = tail;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (DEPTH=16, AFULL_TH=14) with a queue scoreboard
// and hand-computed checks for fill/drain, full/empty push+pop, wrap, flush and reset.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        i_flush;
  logic        i_push;
  logic [31:0] i_WrDat;
  logic        i_pop;
  logic [31:0] o_RdDat;
  logic        o_RdVld;
  logic        o_push_ok;
  logic        o_pop_ok;
  logic        o_full;
  logic        o_empty;
  logic        o_afull;
  logic [4:0]  o_count;
  logic [3:0]  o_head_idx;
  logic [3:0]  o_tail_idx;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mq[$];
  int          m_head = 0;
  int          m_tail = 0;

  param_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .i_flush    (i_flush),
    .i_push     (i_push),
    .i_WrDat    (i_WrDat),
    .i_pop      (i_pop),
    .o_RdDat    (o_RdDat),
    .o_RdVld    (o_RdVld),
    .o_push_ok  (o_push_ok),
    .o_pop_ok   (o_pop_ok),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_afull    (o_afull),
    .o_count    (o_count),
    .o_head_idx (o_head_idx),
    .o_tail_idx (o_tail_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // One clock of traffic. Called #1 after a rising edge; returns #1 after the next one.
  task automatic cycle(input logic e, input logic f, input logic pu, input logic po,
                       input logic [31:0] d);
    logic exp_pop, exp_push;
    logic [31:0] popped;
    en = e; i_flush = f; i_push = pu; i_pop = po; i_WrDat = d;
    #1;
    exp_pop  = e && !f && po && (mq.size() != 0);
    exp_push = e && !f && pu && ((mq.size() < 16) || exp_pop);
    check("pop_ok", 32'(o_pop_ok), 32'(exp_pop));
    check("push_ok", 32'(o_push_ok), 32'(exp_push));
    popped = 32'h0;
    if (exp_pop) begin
      popped = mq[0];
      check("pop_dat", o_RdDat, mq[0]);
    end
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      if (exp_pop) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % 16;
      end
      if (exp_push) begin
        mq.push_back(d);
        m_tail = (m_tail + 1) % 16;
      end
    end
    check("count", 32'(o_count), 32'(mq.size()));
    check("empty", 32'(o_empty), 32'(mq.size() == 0));
    check("rdvld", 32'(o_RdVld), 32'(mq.size() != 0));
    check("full", 32'(o_full), 32'(mq.size() == 16));
    check("afull", 32'(o_afull), 32'(mq.size() >= 14));
    check("head", 32'(o_head_idx), 32'(m_head));
    check("tail", 32'(o_tail_idx), 32'(m_tail));
    if (mq.size() != 0) check("head_dat", o_RdDat, mq[0]);
    $display("txn en=%0b fl=%0b push=%0b pop=%0b wd=0x%0h popped=0x%0h cnt=%0d h=%0d t=%0d",
             e, f, exp_push, exp_pop, d, popped, o_count, o_head_idx, o_tail_idx);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; i_flush = 1'b0; i_push = 1'b0; i_pop = 1'b0; i_WrDat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_afull", 32'(o_afull), 32'd0);
    check("rst_rdvld", 32'(o_RdVld), 32'd0);
    check("rst_rddat", o_RdDat, 32'h0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_tail", 32'(o_tail_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2: fill to 16, overflow attempt, drain in order
    for (int k = 0; k < 16; k++) begin
      cycle(1, 0, 1, 0, 32'h100 + 32'(k));
      check("t2_afull", 32'(o_afull), 32'(k + 1 >= 14));
    end
    check("t2_full", 32'(o_full), 32'd1);
    cycle(1, 0, 1, 0, 32'hDEAD);
    check("t2_ovf_cnt", 32'(o_count), 32'd16);
    for (int k = 0; k < 16; k++) begin
      en = 1'b1; i_pop = 1'b1; i_push = 1'b0; #1;
      check("t2_drain", o_RdDat, 32'h100 + 32'(k));
      #1;
      cycle(1, 0, 0, 1, 32'h0);
    end
    check("t2_empty", 32'(o_empty), 32'd1);

    // T3: push+pop while full
    for (int k = 0; k < 16; k++) cycle(1, 0, 1, 0, 32'h300 + 32'(k));
    cycle(1, 0, 1, 1, 32'hAA);
    check("t3_cnt", 32'(o_count), 32'd16);
    check("t3_head", 32'(o_head_idx), 32'd1);
    for (int k = 0; k < 15; k++) cycle(1, 0, 0, 1, 32'h0);
    check("t3_aa", o_RdDat, 32'hAA);
    cycle(1, 0, 0, 1, 32'h0);

    // T4: push+pop while empty -> push only, no bypass
    cycle(1, 0, 1, 1, 32'h55);
    check("t4_vld", 32'(o_RdVld), 32'd1);
    check("t4_dat", o_RdDat, 32'h55);
    cycle(1, 0, 0, 1, 32'h0);

    // T5: 3 pushes / 2 pops for 40 cycles, pointers wrap
    for (int k = 0; k < 40; k++) begin
      if (k % 5 < 3) cycle(1, 0, 1, 0, 32'h200 + 32'(k));
      else           cycle(1, 0, 0, 1, 32'h0);
    end
    check("t5_cnt", 32'(o_count), 32'd8);
    check("t5_tail", 32'(o_tail_idx), 32'd10);
    check("t5_head", 32'(o_head_idx), 32'd2);
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 1, 32'h0);

    // T6: en=0 freezes; flush with en=0 clears and drops a push
    cycle(0, 0, 1, 1, 32'h77);
    check("t6_hold", 32'(o_count), 32'd0);
    for (int k = 0; k < 5; k++) cycle(1, 0, 1, 0, 32'h600 + 32'(k));
    cycle(0, 0, 0, 1, 32'h0);
    check("t6_en0_cnt", 32'(o_count), 32'd5);
    check("t6_en0_dat", o_RdDat, 32'h600);
    cycle(0, 1, 1, 0, 32'h99);
    check("t6_fl_cnt", 32'(o_count), 32'd0);
    check("t6_fl_head", 32'(o_head_idx), 32'd0);
    check("t6_fl_tail", 32'(o_tail_idx), 32'd0);
    cycle(1, 0, 1, 0, 32'h42);
    check("t6_post", o_RdDat, 32'h42);

    // T1: asynchronous reset mid-traffic
    cycle(1, 0, 1, 0, 32'h43);
    en = 1'b1; i_push = 1'b1; i_pop = 1'b0; i_WrDat = 32'h44;
    rst_n = 1'b0;
    #2;
    check("t1_empty", 32'(o_empty), 32'd1);
    check("t1_count", 32'(o_count), 32'd0);
    check("t1_rddat", o_RdDat, 32'h0);
    check("t1_head", 32'(o_head_idx), 32'd0);
    mq.delete(); m_head = 0; m_tail = 0;
    i_push = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 0, 1, 0, 32'h11);
    cycle(1, 0, 0, 1, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
